// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider (DIV / DIVU).
//
// A divide is accepted in IDLE when start=1 and annul=0. Operands are
// converted to magnitudes at acceptance, then one restoring radix-2 step is
// performed per cycle for 32 cycles. The signed result is fixed up on the
// last step and registered into div_high/div_low, which hold until the next
// completing divide or reset. A zero divisor skips iteration and completes
// after one RUN cycle with quotient all-ones and remainder = dividend.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - request a divide (sampled only in IDLE)
//   signed_div - 1 = signed divide, 0 = unsigned (latched with start)
//   dividend   - numerator (latched with start)
//   divisor    - denominator (latched with start)
//   annul      - cancel the in-flight divide; results left unchanged
//   busy       - high in RUN and DONE
//   done       - one-cycle pulse, results valid in that cycle
//   div_high   - remainder (HI)
//   div_low    - quotient (LO)
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_div,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              annul,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] div_high,
   output logic [DATA_W-1:0] div_low
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT             stateR, nextStateS;
   logic [4:0]        cntR;
   logic [DATA_W-1:0] remR, quotR, divMagR, dividendR;
   logic              negQuotR, negRemR, divZeroR;
   logic              busyR, doneR;
   logic [DATA_W-1:0] divHighR, divLowR;

   logic              acceptS, lastStepS, writeResS, fitsS;
   logic [DATA_W:0]   remShiftS;
   logic [DATA_W-1:0] diffS, stepRemS, stepQuotS;
   logic [DATA_W-1:0] resQuotS, resRemS, absDvdS, absDvsS;
   logic [DATA_W-1:0] resHighS, resLowS;

   assign busy     = busyR;
   assign done     = doneR;
   assign div_high = divHighR;
   assign div_low  = divLowR;

   // Acceptance, operand magnitudes and one restoring divide step.
   always_comb begin
      acceptS   = (stateR == IDLE) && start && !annul;
      lastStepS = (cntR == 5'd31);
      absDvdS   = (signed_div && dividend[DATA_W-1]) ? (32'd0 - dividend) : dividend;
      absDvsS   = (signed_div && divisor[DATA_W-1])  ? (32'd0 - divisor)  : divisor;
      // Shift the next dividend bit into the partial remainder; the partial
      // remainder is always below the divisor, so the difference fits 32 bits.
      remShiftS = {remR, quotR[DATA_W-1]};
      fitsS     = (remShiftS >= {1'b0, divMagR});
      diffS     = remShiftS[DATA_W-1:0] - divMagR;
      if (fitsS) begin
         stepRemS = diffS;
      end else begin
         stepRemS = remShiftS[DATA_W-1:0];
      end
      stepQuotS = {quotR[DATA_W-2:0], fitsS};
      resQuotS  = negQuotR ? (32'd0 - stepQuotS) : stepQuotS;
      resRemS   = negRemR  ? (32'd0 - stepRemS)  : stepRemS;
   end

   // Next-state decode and result selection.
   always_comb begin
      nextStateS = stateR;
      writeResS  = 1'b0;
      resHighS   = resRemS;
      resLowS    = resQuotS;
      case (stateR)
         IDLE: begin
            if (acceptS) begin
               nextStateS = RUN;
            end else begin
               nextStateS = IDLE;
            end
         end
         RUN: begin
            if (annul) begin
               nextStateS = IDLE;
            end else if (divZeroR || lastStepS) begin
               nextStateS = DONE;
               writeResS  = 1'b1;
            end else begin
               nextStateS = RUN;
            end
         end
         DONE: begin
            nextStateS = IDLE;
         end
         default: begin
            nextStateS = IDLE;
         end
      endcase
      if (divZeroR) begin
         resHighS = dividendR;
         resLowS  = 32'hFFFF_FFFF;
      end else begin
         resHighS = resRemS;
         resLowS  = resQuotS;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateR <= IDLE;
      end else begin
         stateR <= nextStateS;
      end
   end

   // Operand latch and iteration datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cntR      <= 5'd0;
         remR      <= 32'd0;
         quotR     <= 32'd0;
         divMagR   <= 32'd0;
         dividendR <= 32'd0;
         negQuotR  <= 1'b0;
         negRemR   <= 1'b0;
         divZeroR  <= 1'b0;
      end else if (acceptS) begin
         cntR      <= 5'd0;
         remR      <= 32'd0;
         quotR     <= absDvdS;
         divMagR   <= absDvsS;
         dividendR <= dividend;
         negQuotR  <= signed_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
         negRemR   <= signed_div && dividend[DATA_W-1];
         divZeroR  <= (divisor == 32'd0);
      end else if (stateR == RUN) begin
         cntR      <= cntR + 5'd1;
         remR      <= stepRemS;
         quotR     <= stepQuotS;
      end
   end

   // Registered status and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busyR    <= 1'b0;
         doneR    <= 1'b0;
         divHighR <= 32'd0;
         divLowR  <= 32'd0;
      end else begin
         busyR <= (nextStateS != IDLE);
         doneR <= (nextStateS == DONE);
         if (writeResS) begin
            divHighR <= resHighS;
            divLowR  <= resLowS;
         end
      end
   end

endmodule
